axi4l_master_bridge: RTL and testbench

- Converts the Ibex core data-side request/grant/rvalid interface into single-outstanding AXI4-Lite master transactions on an axi4l_if.
- Sits between the core LSU (or instruction fetch port) and the AXI4-Lite interconnect/slaves, e.g. axi4l_dpramx32.
- Initiator counterpart of the existing AXI4-Lite slaves. Must satisfy the same handshake/stability/reset rules those slaves rely on.

---
 rtl/axi4l_pkg.sv | 28 ++
 rtl/axi4l_if.sv | 41 ++++
 rtl/axi4l_master_bridge.sv | 182 ++++++++++++++++++
 tb/tb_axi4l_master_bridge.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types plus the state encoding of the master bridge.
// The DRAIN state exists only when AXI4L_MASTER_TIMEOUT_EN is defined.
package axi4l_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WADDR_DATA = 3'd1,
        WRESP      = 3'd2,
        RADDR      = 3'd3,
        RRESP      = 3'd4
`ifdef AXI4L_MASTER_TIMEOUT_EN
        ,
        DRAIN      = 3'd5
`endif
    } bridge_state_t;

endpackage

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4l_if;
    import axi4l_pkg::*;

    addr_t      awaddr;
    logic [2:0] awprot;
    logic       awvalid;
    logic       awready;
    data_t      wdata;
    strb_t      wstrb;
    logic       wvalid;
    logic       wready;
    resp_t      bresp;
    logic       bvalid;
    logic       bready;
    addr_t      araddr;
    logic [2:0] arprot;
    logic       arvalid;
    logic       arready;
    data_t      rdata;
    resp_t      rresp;
    logic       rvalid;
    logic       rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi4l_master_bridge.sv
// Ibex-style req/gnt/rvalid port to single-outstanding AXI4-Lite master.
// Define AXI4L_MASTER_TIMEOUT_EN to add a response timeout with a DRAIN state.
module axi4l_master_bridge
    import axi4l_pkg::*;
#(
    parameter logic [2:0]  PROT    = 3'b000,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    axi4l_if.master     axi
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("axi4l_master_bridge: TIMEOUT must be at least 2");
    end

    bridge_state_t state;
    addr_t         addr_q;
    data_t         wdata_q;
    strb_t         be_q;
    logic          awvalid_q;
    logic          wvalid_q;
    logic          arvalid_q;
    logic          bready_q;
    logic          rready_q;
    logic          gnt;
    logic          b_hs;
    logic          r_hs;
    logic          expired;

    assign gnt   = req_i && (state == IDLE) && aresetn;
    assign gnt_o = gnt;
    assign b_hs  = axi.bvalid && bready_q;
    assign r_hs  = axi.rvalid && rready_q;

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = PROT;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = be_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = PROT;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

`ifdef AXI4L_MASTER_TIMEOUT_EN
    localparam int unsigned    TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_SAT  = TW'(TIMEOUT);

    logic [TW-1:0] timer;

    // Counts cycles spent waiting for B/R; cleared in every other state so
    // it reads zero on the first cycle of WRESP/RRESP.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timer <= '0;
        end else if ((state == WRESP) || (state == RRESP)) begin
            if (timer != TIMER_SAT) begin
                timer <= timer + 1'b1;
            end
        end else begin
            timer <= '0;
        end
    end

    assign expired = (timer == TIMER_LAST);
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            err_o     <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt) begin
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        if (we_i) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RADDR;
                        end
                    end
                end
                // AW and W retire independently; leave once neither is pending.
                WADDR_DATA: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (axi.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if ((!awvalid_q || axi.awready) && (!wvalid_q || axi.wready)) begin
                        bready_q <= 1'b1;
                        state    <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_hs) begin
                        rvalid_o <= 1'b1;
                        err_o    <= (axi.bresp != OKAY);
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end else if (expired) begin
`ifdef AXI4L_MASTER_TIMEOUT_EN
                        rvalid_o <= 1'b1;
                        err_o    <= 1'b1;
                        rdata_o  <= '0;
                        state    <= DRAIN;
`endif
                    end
                end
                RADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RRESP;
                    end
                end
                RRESP: begin
                    if (r_hs) begin
                        rvalid_o <= 1'b1;
                        rdata_o  <= axi.rdata;
                        err_o    <= (axi.rresp != OKAY);
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end else if (expired) begin
`ifdef AXI4L_MASTER_TIMEOUT_EN
                        rvalid_o <= 1'b1;
                        err_o    <= 1'b1;
                        rdata_o  <= '0;
                        state    <= DRAIN;
`endif
                    end
                end
`ifdef AXI4L_MASTER_TIMEOUT_EN
                // The core already saw the error; swallow the late response.
                DRAIN: begin
                    if (b_hs || r_hs) begin
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_master_bridge.sv
// Directed self-checking bench for axi4l_master_bridge; the slave side is
// driven by hand. The timeout scenario runs only with AXI4L_MASTER_TIMEOUT_EN.
module tb_axi4l_master_bridge;
    import axi4l_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    axi4l_if axi_bus ();

    axi4l_master_bridge #(
        .PROT    (3'b000),
        .TIMEOUT (16)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .we_i     (we_i),
        .be_i     (be_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .axi      (axi_bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Cycle numbering: cycle 0 is the cycle where gnt_o is high.
    task automatic test_reset();
        req_i   = 1'b1;
        aresetn = 1'b0;
        tick();
        tick();
        n_checks++; if (gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_gnt: got %b want 0", gnt_o); end
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready, rvalid_o, err_o} !== 7'b0) begin
            n_fail++; $display("[TB] FAIL rst_ctrl: got %b want 0000000", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready, rvalid_o, err_o});
        end
        n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_rdata: got %h want 00000000", rdata_o); end
        req_i   = 1'b0;
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_write_zero_wait();
        addr_i = 32'h0000_0010; wdata_i = 32'hDEAD_BEEF; be_i = 4'hF; we_i = 1'b1; req_i = 1'b1;
        axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0;
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready} !== 3'b110) begin n_fail++; $display("[TB] FAIL wr_c1_valid: got %b want 110", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}); end
        n_checks++; if ({axi_bus.awaddr, axi_bus.wdata, axi_bus.wstrb, axi_bus.awprot} !== {32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
            n_fail++; $display("[TB] FAIL wr_c1_payload: got %h/%h/%h/%h want 00000010/deadbeef/f/0", axi_bus.awaddr, axi_bus.wdata, axi_bus.wstrb, axi_bus.awprot);
        end
        tick();
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, rvalid_o} !== 4'b0010) begin n_fail++; $display("[TB] FAIL wr_c2_bready: got %b want 0010", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, rvalid_o}); end
        axi_bus.bvalid = 1'b1; axi_bus.bresp = OKAY;
        tick();
        n_checks++; if ({rvalid_o, err_o, axi_bus.bready} !== 3'b100) begin n_fail++; $display("[TB] FAIL wr_c3_resp: got %b want 100", {rvalid_o, err_o, axi_bus.bready}); end
        axi_bus.bvalid = 1'b0; axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        tick();
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_c4_pulse: got %b want 0", rvalid_o); end
    endtask

    task automatic test_read_zero_wait();
        addr_i = 32'h0000_0010; we_i = 1'b0; req_i = 1'b1; axi_bus.arready = 1'b1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rd_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0;
        n_checks++; if ({axi_bus.arvalid, axi_bus.rready, axi_bus.araddr} !== {2'b10, 32'h10}) begin n_fail++; $display("[TB] FAIL rd_c1_ar: got %b%b %h want 10 00000010", axi_bus.arvalid, axi_bus.rready, axi_bus.araddr); end
        tick();
        n_checks++; if ({axi_bus.arvalid, axi_bus.rready} !== 2'b01) begin n_fail++; $display("[TB] FAIL rd_c2_rready: got %b want 01", {axi_bus.arvalid, axi_bus.rready}); end
        axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'hDEAD_BEEF; axi_bus.rresp = OKAY;
        tick();
        n_checks++; if ({rvalid_o, err_o, axi_bus.rready} !== 3'b100) begin n_fail++; $display("[TB] FAIL rd_c3_resp: got %b want 100", {rvalid_o, err_o, axi_bus.rready}); end
        n_checks++; if (rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL rd_c3_data: got %h want deadbeef", rdata_o); end
        axi_bus.rvalid = 1'b0; axi_bus.rdata = 32'h0; axi_bus.arready = 1'b0;
        tick();
        n_checks++; if ({rvalid_o, rdata_o} !== {1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("[TB] FAIL rd_c4_hold: got %b %h want 0 deadbeef", rvalid_o, rdata_o); end
    endtask

    // awready low in cycles 1-3, wready low in cycle 1: W completes in cycle 2, AW in cycle 4.
    task automatic test_write_stall();
        addr_i = 32'h0000_0020; wdata_i = 32'h1234_5678; be_i = 4'h3; we_i = 1'b1; req_i = 1'b1;
        tick(); req_i = 1'b0; addr_i = 32'hFFFF_FFFF; wdata_i = 32'h0; be_i = 4'h0;
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid} !== 2'b11) begin n_fail++; $display("[TB] FAIL st_c1_valid: got %b want 11", {axi_bus.awvalid, axi_bus.wvalid}); end
        tick();
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.awaddr, axi_bus.wdata, axi_bus.wstrb} !== {2'b11, 32'h20, 32'h1234_5678, 4'h3}) begin
            n_fail++; $display("[TB] FAIL st_c2_stable: got %b%b %h %h %h want 11 00000020 12345678 3", axi_bus.awvalid, axi_bus.wvalid, axi_bus.awaddr, axi_bus.wdata, axi_bus.wstrb);
        end
        axi_bus.wready = 1'b1;
        tick();
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.awaddr} !== {3'b100, 32'h20}) begin n_fail++; $display("[TB] FAIL st_c3_wdrop: got %b%b%b %h want 100 00000020", axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.awaddr); end
        axi_bus.wready = 1'b0;
        tick();
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready} !== 3'b100) begin n_fail++; $display("[TB] FAIL st_c4_awhold: got %b want 100", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}); end
        axi_bus.awready = 1'b1;
        tick();
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready} !== 3'b001) begin n_fail++; $display("[TB] FAIL st_c5_bready: got %b want 001", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready}); end
        axi_bus.awready = 1'b0; axi_bus.bvalid = 1'b1; axi_bus.bresp = OKAY;
        tick();
        n_checks++; if ({rvalid_o, err_o, axi_bus.bready} !== 3'b100) begin n_fail++; $display("[TB] FAIL st_c6_resp: got %b want 100", {rvalid_o, err_o, axi_bus.bready}); end
        axi_bus.bvalid = 1'b0;
        tick();
        n_checks++; if ({rvalid_o, axi_bus.bready} !== 2'b00) begin n_fail++; $display("[TB] FAIL st_c7_single: got %b want 00", {rvalid_o, axi_bus.bready}); end
    endtask

    task automatic test_read_error_back_to_back();
        addr_i = 32'h0000_0044; we_i = 1'b0; req_i = 1'b1; axi_bus.arready = 1'b1;
        tick(); req_i = 1'b0;
        tick();
        axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'hBAD0_0BAD; axi_bus.rresp = SLVERR;
        tick();
        n_checks++; if ({rvalid_o, err_o, rdata_o} !== {2'b11, 32'hBAD0_0BAD}) begin n_fail++; $display("[TB] FAIL err_resp: got %b%b %h want 11 bad00bad", rvalid_o, err_o, rdata_o); end
        axi_bus.rvalid = 1'b0;
        addr_i = 32'h0000_0048; req_i = 1'b1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0;
        n_checks++; if ({axi_bus.arvalid, rvalid_o, axi_bus.araddr, rdata_o} !== {2'b10, 32'h48, 32'hBAD0_0BAD}) begin
            n_fail++; $display("[TB] FAIL b2b_ar: got %b%b %h %h want 10 00000048 bad00bad", axi_bus.arvalid, rvalid_o, axi_bus.araddr, rdata_o);
        end
        tick();
        axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'h0000_CAFE; axi_bus.rresp = OKAY;
        tick();
        n_checks++; if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'h0000_CAFE}) begin n_fail++; $display("[TB] FAIL b2b_resp: got %b%b %h want 10 0000cafe", rvalid_o, err_o, rdata_o); end
        axi_bus.rvalid = 1'b0; axi_bus.arready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        addr_i = 32'h0000_0030; wdata_i = 32'h0BAD_F00D; be_i = 4'hF; we_i = 1'b1; req_i = 1'b1;
        axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
        tick(); req_i = 1'b0;
        tick();
        n_checks++; if (axi_bus.bready !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_wresp: got %b want 1", axi_bus.bready); end
        aresetn = 1'b0; axi_bus.bvalid = 1'b1; axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        tick();
        n_checks++; if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready, rvalid_o, err_o, rdata_o} !== 39'h0) begin
            n_fail++; $display("[TB] FAIL rm_clear: got %b %h want 0000000 00000000", {axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid, axi_bus.bready, axi_bus.rready, rvalid_o, err_o}, rdata_o);
        end
        req_i = 1'b1; #1;
        n_checks++; if (gnt_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_gnt: got %b want 0", gnt_o); end
        req_i = 1'b0; aresetn = 1'b1; axi_bus.bvalid = 1'b0;
        tick();
        n_checks++; if (rvalid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rm_no_pulse: got %b want 0", rvalid_o); end
        addr_i = 32'h0000_0010; we_i = 1'b0; req_i = 1'b1; axi_bus.arready = 1'b1;
        #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_rd_gnt: got %b want 1", gnt_o); end
        tick(); req_i = 1'b0;
        tick();
        axi_bus.rvalid = 1'b1; axi_bus.rdata = 32'h5555_AAAA; axi_bus.rresp = OKAY;
        tick();
        n_checks++; if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'h5555_AAAA}) begin n_fail++; $display("[TB] FAIL rm_rd_resp: got %b%b %h want 10 5555aaaa", rvalid_o, err_o, rdata_o); end
        axi_bus.rvalid = 1'b0; axi_bus.arready = 1'b0;
        tick();
    endtask

`ifdef AXI4L_MASTER_TIMEOUT_EN
    // WRESP entered in cycle 2; error pulse due in cycle 18; late B in cycle 22.
    task automatic test_timeout();
        logic early;
        logic leaked;
        early  = 1'b0;
        leaked = 1'b0;
        addr_i = 32'h0000_0040; wdata_i = 32'h1111_2222; be_i = 4'hF; we_i = 1'b1; req_i = 1'b1;
        axi_bus.awready = 1'b1; axi_bus.wready = 1'b1;
        tick(); req_i = 1'b0;
        tick();
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0;
        n_checks++; if (axi_bus.bready !== 1'b1) begin n_fail++; $display("[TB] FAIL to_wresp: got %b want 1", axi_bus.bready); end
        for (int c = 3; c < 18; c++) begin
            tick();
            if (rvalid_o !== 1'b0) early = 1'b1;
        end
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("[TB] FAIL to_early: got %b want 0", early); end
        tick();
        n_checks++; if ({rvalid_o, err_o, axi_bus.bready, rdata_o} !== {3'b111, 32'h0}) begin n_fail++; $display("[TB] FAIL to_pulse: got %b%b%b %h want 111 00000000", rvalid_o, err_o, axi_bus.bready, rdata_o); end
        for (int c = 19; c < 23; c++) begin
            req_i = 1'b1; #1;
            if (gnt_o !== 1'b0) leaked = 1'b1;
            req_i = 1'b0;
            if (c == 22) axi_bus.bvalid = 1'b1;
            tick();
        end
        n_checks++; if (leaked !== 1'b0) begin n_fail++; $display("[TB] FAIL to_drain_gnt: got %b want 0", leaked); end
        n_checks++; if ({rvalid_o, axi_bus.bready} !== 2'b00) begin n_fail++; $display("[TB] FAIL to_absorb: got %b want 00", {rvalid_o, axi_bus.bready}); end
        axi_bus.bvalid = 1'b0;
        req_i = 1'b1; we_i = 1'b0; #1;
        n_checks++; if (gnt_o !== 1'b1) begin n_fail++; $display("[TB] FAIL to_idle_gnt: got %b want 1", gnt_o); end
        req_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
        axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0; axi_bus.bresp = OKAY;
        axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rdata = 32'h0; axi_bus.rresp = OKAY;
        test_reset();
        test_write_zero_wait();
        test_read_zero_wait();
        test_write_stall();
        test_read_error_back_to_back();
        test_reset_mid();
`ifdef AXI4L_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
